// File: rtl/ocp3_nic_card_pwr_ctrl_pkg.sv
// Shared encodings for the OCP3 NIC card power controller.
package ocp3_nic_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLT_W   = 2;
  localparam int unsigned MS_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    S0_OFF       = 4'd0,
    S1_AUX_RAMP  = 4'd1,
    S2_AUX_ON    = 4'd2,
    S3_MAIN_RAMP = 4'd3,
    S4_MAIN_ON   = 4'd4,
    S5_MAIN_OFF  = 4'd5,
    S6_FAULT     = 4'd6
  } state_t;

  localparam logic [FLT_W-1:0] FLT_NONE     = 2'b00;
  localparam logic [FLT_W-1:0] FLT_AUX_TMO  = 2'b01;
  localparam logic [FLT_W-1:0] FLT_MAIN_TMO = 2'b10;
  localparam logic [FLT_W-1:0] FLT_PG_LOST  = 2'b11;

endpackage

// File: rtl/ocp3_nic_card_pwr_ctrl_if.sv
// Baseboard/regulator facing signal bundle of the card power controller.
interface ocp3_nic_card_pwr_ctrl_if;
  import ocp3_nic_pkg::*;

  logic               iNIC_AUX_PWR_EN;
  logic               iNIC_MAIN_PWR_EN;
  logic               iRST_NIC_PERST_N;
  logic               iAUX_RAIL_PG;
  logic               iMAIN_RAIL_PG;
  logic               oAUX_RAIL_EN;
  logic               oMAIN_RAIL_EN;
  logic               oPWRGD_NIC_PWR_GOOD;
  logic               oNIC_PERST_N;
  logic               oFAULT;
  logic [FLT_W-1:0]   oFAULT_CODE;
  logic [STATE_W-1:0] oDBG_FSM_curr;

  // Baseboard + regulators side.
  modport master (
    output iNIC_AUX_PWR_EN, iNIC_MAIN_PWR_EN, iRST_NIC_PERST_N,
           iAUX_RAIL_PG, iMAIN_RAIL_PG,
    input  oAUX_RAIL_EN, oMAIN_RAIL_EN, oPWRGD_NIC_PWR_GOOD,
           oNIC_PERST_N, oFAULT, oFAULT_CODE, oDBG_FSM_curr
  );

  // Card controller side.
  modport slave (
    input  iNIC_AUX_PWR_EN, iNIC_MAIN_PWR_EN, iRST_NIC_PERST_N,
           iAUX_RAIL_PG, iMAIN_RAIL_PG,
    output oAUX_RAIL_EN, oMAIN_RAIL_EN, oPWRGD_NIC_PWR_GOOD,
           oNIC_PERST_N, oFAULT, oFAULT_CODE, oDBG_FSM_curr
  );

endinterface

// File: rtl/ocp3_nic_card_pwr_ctrl_ms_tick_timer.sv
// Free-running ms prescaler plus a clearable 16-bit saturating ms counter.
module ms_tick_timer
  import ocp3_nic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2000
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic            iClr,
  output logic [MS_W-1:0] oMsCnt
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [MS_W-1:0] MS_MAX = '1;

  logic [PRE_W-1:0] preCnt;
  logic             tick;

  assign tick = (preCnt == PRE_W'(TICK_DIV - 1));

  // Prescaler: wraps every TICK_DIV cycles, never cleared by the FSM.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)   preCnt <= '0;
    else if (tick) preCnt <= '0;
    else           preCnt <= preCnt + PRE_W'(1);
  end

  // ms counter: clear has priority over the tick, holds at full scale.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                        oMsCnt <= '0;
    else if (iClr)                      oMsCnt <= '0;
    else if (tick && (oMsCnt != MS_MAX)) oMsCnt <= oMsCnt + MS_W'(1);
  end

endmodule

// File: rtl/ocp3_nic_card_pwr_ctrl.sv
// Card-side responder to the baseboard OCP3 NIC power sequencer.
module ocp3_nic_card_pwr_ctrl
  import ocp3_nic_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 2000,
  parameter int unsigned AUX_PG_TMO_MS  = 50,
  parameter int unsigned MAIN_PG_TMO_MS = 100,
  parameter int unsigned MAIN_OFF_MS    = 1
) (
  input logic                     iClk,
  input logic                     iRst_n,
  ocp3_nic_card_pwr_ctrl_if.slave bus
);

  localparam int unsigned SYNC_W = 5;
  localparam int unsigned IDX_AUX_EN  = 4;
  localparam int unsigned IDX_MAIN_EN = 3;
  localparam int unsigned IDX_PERST   = 2;
  localparam int unsigned IDX_AUX_PG  = 1;
  localparam int unsigned IDX_MAIN_PG = 0;

  logic [SYNC_W-1:0] syncMeta, syncQ;
  logic auxEn, mainEn, perstN, auxPg, mainPg;

  state_t            state, stateNext;
  logic [MS_W-1:0]   msCnt;
  logic              msClr;

  logic auxRailEn, mainRailEn, pwrGood, nicPerstN, fault;
  logic auxRailEnNxt, mainRailEnNxt, pwrGoodNxt, nicPerstNNxt, faultNxt;
  logic [FLT_W-1:0]  fltCode, fltCodeNxt;

  // Two-flop synchroniser for every asynchronous pin.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      syncMeta <= '0;
      syncQ    <= '0;
    end else begin
      syncMeta <= {bus.iNIC_AUX_PWR_EN, bus.iNIC_MAIN_PWR_EN, bus.iRST_NIC_PERST_N,
                   bus.iAUX_RAIL_PG, bus.iMAIN_RAIL_PG};
      syncQ    <= syncMeta;
    end
  end

  assign auxEn  = syncQ[IDX_AUX_EN];
  assign mainEn = syncQ[IDX_MAIN_EN];
  assign perstN = syncQ[IDX_PERST];
  assign auxPg  = syncQ[IDX_AUX_PG];
  assign mainPg = syncQ[IDX_MAIN_PG];

  // Dwell timer restarts whenever the state changes.
  assign msClr = (stateNext != state);

  ms_tick_timer #(.TICK_DIV(TICK_DIV)) uTimer (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (msClr),
    .oMsCnt (msCnt)
  );

  // State and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= S0_OFF;
      auxRailEn  <= 1'b0;
      mainRailEn <= 1'b0;
      pwrGood    <= 1'b0;
      nicPerstN  <= 1'b0;
      fault      <= 1'b0;
      fltCode    <= FLT_NONE;
    end else begin
      state      <= stateNext;
      auxRailEn  <= auxRailEnNxt;
      mainRailEn <= mainRailEnNxt;
      pwrGood    <= pwrGoodNxt;
      nicPerstN  <= nicPerstNNxt;
      fault      <= faultNxt;
      fltCode    <= fltCodeNxt;
    end
  end

  // Next state: PG loss > aux_en low > main_en low > forward progress > timeout.
  always_comb begin
    stateNext  = state;
    fltCodeNxt = fltCode;
    case (state)
      S0_OFF: begin
        if (auxEn) stateNext = S1_AUX_RAMP;
      end
      S1_AUX_RAMP: begin
        if (!auxEn)      stateNext = S0_OFF;
        else if (auxPg)  stateNext = S2_AUX_ON;
        else if (msCnt >= MS_W'(AUX_PG_TMO_MS)) begin
          stateNext  = S6_FAULT;
          fltCodeNxt = FLT_AUX_TMO;
        end
      end
      S2_AUX_ON: begin
        if (!auxPg) begin
          stateNext  = S6_FAULT;
          fltCodeNxt = FLT_PG_LOST;
        end
        else if (!auxEn) stateNext = S0_OFF;
        else if (mainEn) stateNext = S3_MAIN_RAMP;
      end
      S3_MAIN_RAMP: begin
        if (!auxPg) begin
          stateNext  = S6_FAULT;
          fltCodeNxt = FLT_PG_LOST;
        end
        else if (!auxEn)  stateNext = S0_OFF;
        else if (!mainEn) stateNext = S5_MAIN_OFF;
        else if (mainPg)  stateNext = S4_MAIN_ON;
        else if (msCnt >= MS_W'(MAIN_PG_TMO_MS)) begin
          stateNext  = S6_FAULT;
          fltCodeNxt = FLT_MAIN_TMO;
        end
      end
      S4_MAIN_ON: begin
        if (!auxPg || !mainPg) begin
          stateNext  = S6_FAULT;
          fltCodeNxt = FLT_PG_LOST;
        end
        else if (!auxEn)  stateNext = S0_OFF;
        else if (!mainEn) stateNext = S5_MAIN_OFF;
      end
      S5_MAIN_OFF: begin
        if (!auxEn) stateNext = S0_OFF;
        else if ((msCnt >= MS_W'(MAIN_OFF_MS)) && !mainPg) stateNext = S2_AUX_ON;
      end
      S6_FAULT: begin
        if (!auxEn) stateNext = S0_OFF;
      end
      default: stateNext = S0_OFF;
    endcase

    auxRailEnNxt  = (stateNext == S1_AUX_RAMP) || (stateNext == S2_AUX_ON) ||
                    (stateNext == S3_MAIN_RAMP) || (stateNext == S4_MAIN_ON) ||
                    (stateNext == S5_MAIN_OFF);
    mainRailEnNxt = (stateNext == S3_MAIN_RAMP) || (stateNext == S4_MAIN_ON);
    pwrGoodNxt    = (stateNext == S2_AUX_ON) || (stateNext == S3_MAIN_RAMP) ||
                    (stateNext == S4_MAIN_ON) || (stateNext == S5_MAIN_OFF);
    nicPerstNNxt  = (stateNext == S4_MAIN_ON) && perstN;
    faultNxt      = (stateNext == S6_FAULT);
  end

  assign bus.oAUX_RAIL_EN        = auxRailEn;
  assign bus.oMAIN_RAIL_EN       = mainRailEn;
  assign bus.oPWRGD_NIC_PWR_GOOD = pwrGood;
  assign bus.oNIC_PERST_N        = nicPerstN;
  assign bus.oFAULT              = fault;
  assign bus.oFAULT_CODE         = fltCode;
  assign bus.oDBG_FSM_curr       = state;

endmodule

// File: tb/tb_ocp3_nic_card_pwr_ctrl.sv
// Directed self-checking bench for the OCP3 NIC card power controller.
module tb_ocp3_nic_card_pwr_ctrl;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int   nTests = 0;
  int   nFail  = 0;

  ocp3_nic_card_pwr_ctrl_if bus();

  ocp3_nic_card_pwr_ctrl #(
    .TICK_DIV       (4),
    .AUX_PG_TMO_MS  (50),
    .MAIN_PG_TMO_MS (100),
    .MAIN_OFF_MS    (1)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus.slave)
  );

  always #5 iClk = ~iClk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int maxc, output bit ok);
    ok = (bus.oDBG_FSM_curr == s);
    for (int i = 0; i < maxc && !ok; i++) begin
      cyc(1);
      ok = (bus.oDBG_FSM_curr == s);
    end
  endtask

  task automatic set_inputs(input logic auxEn, input logic mainEn, input logic perst,
                            input logic auxPg, input logic mainPg);
    bus.iNIC_AUX_PWR_EN  = auxEn;
    bus.iNIC_MAIN_PWR_EN = mainEn;
    bus.iRST_NIC_PERST_N = perst;
    bus.iAUX_RAIL_PG     = auxPg;
    bus.iMAIN_RAIL_PG    = mainPg;
  endtask

  function automatic logic [5:0] outs();
    return {bus.oAUX_RAIL_EN, bus.oMAIN_RAIL_EN, bus.oPWRGD_NIC_PWR_GOOD,
            bus.oNIC_PERST_N, bus.oFAULT_CODE};
  endfunction

  task automatic test_reset();
    set_inputs(0, 0, 0, 0, 0);
    #2;
    nTests++; if ({outs(), bus.oFAULT} !== 7'b0) begin nFail++; $display("FAIL rst_outs: got %b want 0", {outs(), bus.oFAULT}); end
    nTests++; if (bus.oDBG_FSM_curr !== 4'd0) begin nFail++; $display("FAIL rst_state: got %0d want 0", bus.oDBG_FSM_curr); end
    cyc(2);
    iRst_n = 1'b1;
    cyc(10);
    nTests++; if (bus.oDBG_FSM_curr !== 4'd0) begin nFail++; $display("FAIL rst_idle: got %0d want 0", bus.oDBG_FSM_curr); end
  endtask

  task automatic test_power_up();
    bus.iNIC_AUX_PWR_EN = 1'b1;
    cyc(2);
    nTests++; if (bus.oAUX_RAIL_EN !== 1'b0) begin nFail++; $display("FAIL pu_aux_early: got %b want 0", bus.oAUX_RAIL_EN); end
    cyc(1);
    nTests++; if (bus.oAUX_RAIL_EN !== 1'b1) begin nFail++; $display("FAIL pu_aux_en: got %b want 1", bus.oAUX_RAIL_EN); end
    nTests++; if (bus.oDBG_FSM_curr !== 4'd1) begin nFail++; $display("FAIL pu_s1: got %0d want 1", bus.oDBG_FSM_curr); end
    cyc(5);
    bus.iAUX_RAIL_PG = 1'b1;
    cyc(2);
    nTests++; if (bus.oPWRGD_NIC_PWR_GOOD !== 1'b0) begin nFail++; $display("FAIL pu_pg_early: got %b want 0", bus.oPWRGD_NIC_PWR_GOOD); end
    cyc(1);
    nTests++; if ({bus.oPWRGD_NIC_PWR_GOOD, bus.oDBG_FSM_curr} !== {1'b1, 4'd2}) begin nFail++; $display("FAIL pu_pwrgd: got pg=%b st=%0d want pg=1 st=2", bus.oPWRGD_NIC_PWR_GOOD, bus.oDBG_FSM_curr); end
    bus.iNIC_MAIN_PWR_EN = 1'b1;
    cyc(2);
    nTests++; if (bus.oMAIN_RAIL_EN !== 1'b0) begin nFail++; $display("FAIL pu_main_early: got %b want 0", bus.oMAIN_RAIL_EN); end
    cyc(1);
    nTests++; if ({bus.oMAIN_RAIL_EN, bus.oDBG_FSM_curr} !== {1'b1, 4'd3}) begin nFail++; $display("FAIL pu_main_en: got en=%b st=%0d want en=1 st=3", bus.oMAIN_RAIL_EN, bus.oDBG_FSM_curr); end
    bus.iMAIN_RAIL_PG = 1'b1;
    cyc(3);
    nTests++; if ({bus.oDBG_FSM_curr, bus.oNIC_PERST_N} !== {4'd4, 1'b0}) begin nFail++; $display("FAIL pu_s4: got st=%0d perst=%b want st=4 perst=0", bus.oDBG_FSM_curr, bus.oNIC_PERST_N); end
    bus.iRST_NIC_PERST_N = 1'b1;
    cyc(2);
    nTests++; if (bus.oNIC_PERST_N !== 1'b0) begin nFail++; $display("FAIL pu_perst_early: got %b want 0", bus.oNIC_PERST_N); end
    cyc(1);
    nTests++; if ({outs(), bus.oFAULT} !== 7'b1111_00_0) begin nFail++; $display("FAIL pu_final: got %b want 1111000", {outs(), bus.oFAULT}); end
  endtask

  task automatic test_graceful_off();
    bit ok;
    bus.iNIC_MAIN_PWR_EN = 1'b0;
    cyc(2);
    nTests++; if ({bus.oMAIN_RAIL_EN, bus.oNIC_PERST_N} !== 2'b11) begin nFail++; $display("FAIL go_hold: got %b want 11", {bus.oMAIN_RAIL_EN, bus.oNIC_PERST_N}); end
    cyc(1);
    nTests++; if ({bus.oMAIN_RAIL_EN, bus.oNIC_PERST_N, bus.oPWRGD_NIC_PWR_GOOD, bus.oDBG_FSM_curr} !== {3'b001, 4'd5}) begin nFail++; $display("FAIL go_s5: got main=%b perst=%b pg=%b st=%0d want 0 0 1 5", bus.oMAIN_RAIL_EN, bus.oNIC_PERST_N, bus.oPWRGD_NIC_PWR_GOOD, bus.oDBG_FSM_curr); end
    bus.iMAIN_RAIL_PG = 1'b0;
    wait_state(4'd2, 20, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL go_to_s2: got st=%0d want 2 within 20 cycles", bus.oDBG_FSM_curr); end
    nTests++; if ({bus.oAUX_RAIL_EN, bus.oMAIN_RAIL_EN, bus.oPWRGD_NIC_PWR_GOOD, bus.oFAULT} !== 4'b1010) begin nFail++; $display("FAIL go_s2_outs: got %b want 1010", {bus.oAUX_RAIL_EN, bus.oMAIN_RAIL_EN, bus.oPWRGD_NIC_PWR_GOOD, bus.oFAULT}); end
    bus.iNIC_MAIN_PWR_EN = 1'b1;
    bus.iMAIN_RAIL_PG    = 1'b1;
    wait_state(4'd4, 20, ok);
    cyc(1);
    nTests++; if (!ok || bus.oNIC_PERST_N !== 1'b1) begin nFail++; $display("FAIL go_back_s4: got st=%0d perst=%b want 4 1", bus.oDBG_FSM_curr, bus.oNIC_PERST_N); end
  endtask

  task automatic test_pg_loss();
    bus.iMAIN_RAIL_PG = 1'b0;
    cyc(2);
    nTests++; if (bus.oDBG_FSM_curr !== 4'd4) begin nFail++; $display("FAIL pl_hold: got %0d want 4", bus.oDBG_FSM_curr); end
    cyc(1);
    nTests++; if ({outs(), bus.oFAULT, bus.oDBG_FSM_curr} !== {6'b0000_11, 1'b1, 4'd6}) begin nFail++; $display("FAIL pl_fault: got outs=%b flt=%b st=%0d want 000011 1 6", outs(), bus.oFAULT, bus.oDBG_FSM_curr); end
    set_inputs(0, 0, 0, 0, 0);
    cyc(3);
    nTests++; if ({bus.oDBG_FSM_curr, bus.oFAULT, bus.oFAULT_CODE} !== {4'd0, 1'b0, 2'b11}) begin nFail++; $display("FAIL pl_exit: got st=%0d flt=%b code=%b want 0 0 11", bus.oDBG_FSM_curr, bus.oFAULT, bus.oFAULT_CODE); end
  endtask

  task automatic test_aux_timeout();
    int n;
    bit ok;
    bus.iNIC_AUX_PWR_EN = 1'b1;
    wait_state(4'd1, 10, ok);
    nTests++; if (!ok || bus.oAUX_RAIL_EN !== 1'b1) begin nFail++; $display("FAIL at_s1: got st=%0d en=%b want 1 1", bus.oDBG_FSM_curr, bus.oAUX_RAIL_EN); end
    n = 0;
    while (bus.oFAULT !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    // 50 ms of 4-cycle ticks: up to one tick of phase slack plus the registered decision.
    nTests++; if (n < 196 || n > 201) begin nFail++; $display("FAIL at_delay: got %0d cycles want 196..201", n); end
    nTests++; if ({bus.oDBG_FSM_curr, bus.oFAULT_CODE, bus.oAUX_RAIL_EN, bus.oPWRGD_NIC_PWR_GOOD} !== {4'd6, 2'b01, 2'b00}) begin nFail++; $display("FAIL at_fault: got st=%0d code=%b en=%b pg=%b want 6 01 0 0", bus.oDBG_FSM_curr, bus.oFAULT_CODE, bus.oAUX_RAIL_EN, bus.oPWRGD_NIC_PWR_GOOD); end
    bus.iNIC_AUX_PWR_EN = 1'b0;
    cyc(3);
    nTests++; if ({bus.oDBG_FSM_curr, bus.oFAULT, bus.oFAULT_CODE} !== {4'd0, 1'b0, 2'b01}) begin nFail++; $display("FAIL at_exit: got st=%0d flt=%b code=%b want 0 0 01", bus.oDBG_FSM_curr, bus.oFAULT, bus.oFAULT_CODE); end
  endtask

  task automatic test_surprise_removal();
    bit ok;
    bus.iNIC_AUX_PWR_EN = 1'b1;
    bus.iAUX_RAIL_PG    = 1'b1;
    wait_state(4'd2, 20, ok);
    bus.iNIC_MAIN_PWR_EN = 1'b1;
    wait_state(4'd3, 20, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL sr_s3: got st=%0d want 3", bus.oDBG_FSM_curr); end
    bus.iNIC_AUX_PWR_EN = 1'b0;
    bus.iMAIN_RAIL_PG   = 1'b1;
    cyc(3);
    nTests++; if ({outs(), bus.oFAULT, bus.oDBG_FSM_curr} !== {6'b0000_01, 1'b0, 4'd0}) begin nFail++; $display("FAIL sr_off: got outs=%b flt=%b st=%0d want 000001 0 0", outs(), bus.oFAULT, bus.oDBG_FSM_curr); end
    set_inputs(0, 0, 0, 0, 0);
    cyc(3);
  endtask

  task automatic test_async_reset();
    bit ok;
    set_inputs(1, 1, 1, 1, 1);
    wait_state(4'd4, 30, ok);
    cyc(1);
    nTests++; if (!ok || bus.oNIC_PERST_N !== 1'b1) begin nFail++; $display("FAIL ar_s4: got st=%0d perst=%b want 4 1", bus.oDBG_FSM_curr, bus.oNIC_PERST_N); end
    #2;
    iRst_n = 1'b0;
    #1;
    nTests++; if ({outs(), bus.oFAULT, bus.oDBG_FSM_curr} !== 11'b0) begin nFail++; $display("FAIL ar_drop: got outs=%b flt=%b st=%0d want all 0", outs(), bus.oFAULT, bus.oDBG_FSM_curr); end
    set_inputs(0, 0, 0, 0, 0);
    cyc(2);
    iRst_n = 1'b1;
    cyc(10);
    nTests++; if (bus.oDBG_FSM_curr !== 4'd0) begin nFail++; $display("FAIL ar_idle: got %0d want 0", bus.oDBG_FSM_curr); end
    bus.iNIC_AUX_PWR_EN = 1'b1;
    cyc(3);
    nTests++; if ({bus.oDBG_FSM_curr, bus.oAUX_RAIL_EN} !== {4'd1, 1'b1}) begin nFail++; $display("FAIL ar_restart: got st=%0d en=%b want 1 1", bus.oDBG_FSM_curr, bus.oAUX_RAIL_EN); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_graceful_off();
    test_pg_loss();
    test_aux_timeout();
    test_surprise_removal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
